// File: rtl/div_control_pkg.sv
// Shared definitions for the multi-cycle divide sequencer: state encodings, width and handshake levels.
package div_control_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_BUSY = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_control_step.sv
// One combinational restoring-division iteration on {partial remainder, quotient}.
module div_step
    import div_control_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [2*WIDTH-1:0] rem_quo_in,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] rem_quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        // The remainder is always below the divisor, so one extra bit holds the shifted value exactly.
        shifted = rem_quo_in[2*WIDTH-1:WIDTH-1];
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_quo_out = {trial[WIDTH-1:0], rem_quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_quo_out = {shifted[WIDTH-1:0], rem_quo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_control.sv
// DIV/DIVU sequencer: 32-step restoring divide, stalls the pipe, presents {HI=rem, LO=quo} in DONE.
// Define DIV_ZERO_TRAP_EN to raise div_zero alongside the result of a divide by zero.
module div_control
    import div_control_pkg::*;
#(
    parameter int WIDTH       = DIV_WIDTH,
    parameter int COUNT_WIDTH = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               annul,
    output logic               stall,
    output logic               result_valid,
    output logic [2*WIDTH-1:0] result,
    output logic               div_zero
);

    localparam logic [COUNT_WIDTH-1:0] LAST_STEP = COUNT_WIDTH'(WIDTH - 1);
`ifdef DIV_ZERO_TRAP_EN
    localparam logic ZERO_TRAP = 1'b1;
`else
    localparam logic ZERO_TRAP = 1'b0;
`endif

    div_state_e             state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic [WIDTH-1:0]       quo_q, quo_d;
    logic [WIDTH-1:0]       dvsr_q, dvsr_d;
    logic                   quo_neg_q, quo_neg_d;
    logic                   rem_neg_q, rem_neg_d;
    logic [2*WIDTH-1:0]     result_q, result_d;
    logic                   result_valid_q, result_valid_d;
    logic                   div_zero_q, div_zero_d;

    logic [2*WIDTH-1:0]     step_out;
    logic [WIDTH-1:0]       abs_dividend, abs_divisor;
    logic [WIDTH-1:0]       fix_quo, fix_rem;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_quo_in  ({rem_q, quo_q}),
        .divisor     (dvsr_q),
        .rem_quo_out (step_out)
    );

    always_comb begin
        abs_dividend = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        abs_divisor  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
        fix_quo      = quo_neg_q ? -step_out[WIDTH-1:0] : step_out[WIDTH-1:0];
        fix_rem      = rem_neg_q ? -step_out[2*WIDTH-1:WIDTH] : step_out[2*WIDTH-1:WIDTH];

        state_d        = state_q;
        count_d        = count_q;
        rem_d          = rem_q;
        quo_d          = quo_q;
        dvsr_d         = dvsr_q;
        quo_neg_d      = quo_neg_q;
        rem_neg_d      = rem_neg_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        div_zero_d     = div_zero_q;

        if (annul) begin
            state_d        = DIV_IDLE;
            count_d        = '0;
            result_d       = '0;
            result_valid_d = DivResultNotReady;
            div_zero_d     = 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start == DivStart) begin
                        rem_d     = '0;
                        quo_d     = abs_dividend;
                        dvsr_d    = abs_divisor;
                        quo_neg_d = signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        rem_neg_d = signed_op && dividend[WIDTH-1];
                        count_d   = '0;
                        state_d   = (divisor == '0) ? DIV_ZERO : DIV_BUSY;
                    end
                end
                DIV_ZERO: begin
                    state_d        = DIV_DONE;
                    result_d       = '0;
                    result_valid_d = DivResultReady;
                    div_zero_d     = ZERO_TRAP;
                end
                DIV_BUSY: begin
                    // Losing start mid-divide means the execute stage moved on; abandon like annul.
                    if (start == DivStop) begin
                        state_d = DIV_IDLE;
                        count_d = '0;
                    end else begin
                        rem_d   = step_out[2*WIDTH-1:WIDTH];
                        quo_d   = step_out[WIDTH-1:0];
                        count_d = count_q + COUNT_WIDTH'(1);
                        if (count_q == LAST_STEP) begin
                            state_d        = DIV_DONE;
                            result_d       = {fix_rem, fix_quo};
                            result_valid_d = DivResultReady;
                        end
                    end
                end
                DIV_DONE: begin
                    if (start == DivStop) begin
                        state_d        = DIV_IDLE;
                        result_d       = '0;
                        result_valid_d = DivResultNotReady;
                        div_zero_d     = 1'b0;
                    end
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= DIV_IDLE;
            count_q        <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            dvsr_q         <= '0;
            quo_neg_q      <= 1'b0;
            rem_neg_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= DivResultNotReady;
            div_zero_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            rem_q          <= rem_d;
            quo_q          <= quo_d;
            dvsr_q         <= dvsr_d;
            quo_neg_q      <= quo_neg_d;
            rem_neg_q      <= rem_neg_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            div_zero_q     <= div_zero_d;
        end
    end

    always_comb begin
        stall = 1'b0;
        if (reset && !annul) begin
            stall = (state_q == DIV_BUSY) || (state_q == DIV_ZERO) ||
                    (state_q == DIV_IDLE && start == DivStart);
        end
    end

    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign div_zero     = div_zero_q;

endmodule

// File: tb/tb_div_control.sv
// Directed bench for div_control: latency, stall, signed/unsigned results, divide by zero, annul and reset.
module tb_div_control;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        stall;
    logic        result_valid;
    logic [63:0] result;
    logic        div_zero;

    int tests = 0;
    int fails = 0;

`ifdef DIV_ZERO_TRAP_EN
    localparam logic EXP_DZ = 1'b1;
`else
    localparam logic EXP_DZ = 1'b0;
`endif

    always #5 clock = ~clock;

    div_control dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .signed_op    (signed_op),
        .dividend     (dividend),
        .divisor      (divisor),
        .annul        (annul),
        .stall        (stall),
        .result_valid (result_valid),
        .result       (result),
        .div_zero     (div_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat,
                           input logic [63:0] exp_res, input logic exp_dz);
        int n;
        int stalls;
        @(negedge clock);
        signed_op = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        #1;
        n      = 0;
        stalls = 0;
        while (!result_valid && n < 40) begin
            if (stall) stalls++;
            @(negedge clock);
            // Operands must have been captured at accept.
            dividend = 32'hDEAD_BEEF;
            divisor  = 32'h0000_0003;
            #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_lat));
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
        chk({tag, "_stall_done"}, 64'(stall), 64'd0);
        @(negedge clock); #1;
        chk({tag, "_hold_valid"}, 64'(result_valid), 64'd1);
        chk({tag, "_hold_result"}, result, exp_res);
        @(negedge clock);
        start = 1'b0;
        #1;
        chk({tag, "_drop_valid"}, 64'(result_valid), 64'd1);
        @(negedge clock); #1;
        chk({tag, "_idle_valid"}, 64'(result_valid), 64'd0);
        chk({tag, "_idle_result"}, result, 64'd0);
        chk({tag, "_idle_dz"}, 64'(div_zero), 64'd0);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        annul     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clock);
        #1;
        chk("reset_valid", 64'(result_valid), 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_dz", 64'(div_zero), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        start = 1'b1;
        #1;
        chk("reset_stall_start", 64'(stall), 64'd0);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, {32'h0000_0002, 32'h0000_000E}, 1'b0);
        run_div("divu_big", 1'b0, 32'hFFFF_0000, 32'h0505_0000, 33, {32'h0000_0000, 32'h0000_0033}, 1'b0);
        run_div("div_big", 1'b1, 32'hFFFF_0000, 32'h0505_0000, 33, {32'hFFFF_0000, 32'h0000_0000}, 1'b0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0000_0000, 32'h8000_0000}, 1'b0);
        run_div("div_zero", 1'b0, 32'd12345, 32'd0, 2, 64'd0, EXP_DZ);

        // Annul during BUSY step 10.
        @(negedge clock);
        signed_op = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        start     = 1'b1;
        repeat (10) @(negedge clock);
        #1;
        chk("annul_busy_stall_before", 64'(stall), 64'd1);
        annul = 1'b1;
        #1;
        chk("annul_stall_same_cycle", 64'(stall), 64'd0);
        @(negedge clock);
        annul = 1'b0;
        start = 1'b0;
        #1;
        chk("annul_idle_stall", 64'(stall), 64'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clock); #1;
                if (result_valid) seen++;
            end
            chk("annul_no_valid", 64'(seen), 64'd0);
        end
        run_div("divu_after_annul", 1'b0, 32'd100, 32'd7, 33, {32'h0000_0002, 32'h0000_000E}, 1'b0);

        // Reset pulse during BUSY.
        @(negedge clock);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_busy_stall_gated", 64'(stall), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        #1;
        chk("rst_busy_stall", 64'(stall), 64'd0);
        chk("rst_busy_valid", 64'(result_valid), 64'd0);
        chk("rst_busy_result", result, 64'd0);

        // start and annul together in IDLE: no accept.
        @(negedge clock);
        start = 1'b1;
        annul = 1'b1;
        #1;
        chk("start_annul_stall", 64'(stall), 64'd0);
        @(negedge clock);
        start = 1'b0;
        annul = 1'b0;
        #1;
        chk("start_annul_no_accept", 64'(stall), 64'd0);
        @(negedge clock); #1;
        chk("start_annul_no_valid", 64'(result_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_control.md
Name: div_control

Overview:
- Multi-cycle divide sequencer for the CPU's HI/LO path.
- Runs DIV/DIVU as a 32-step restoring division.
- Holds the pipeline stalled while the division runs, then presents {HI = remainder, LO = quotient} to the execute stage for the HI/LO write.
- Sits beside the execute stage; consumes the stage's annul/flush.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are WIDTH bits each, result is 2*WIDTH.
- COUNT_WIDTH, 6, step counter width; must hold the value WIDTH.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge clears all state.
- start  input  1  divide request; held high by the execute stage until result_valid is seen.
- signed_op  input  1  1 = DIV (signed), 0 = DIVU.
- dividend  input  WIDTH  rs operand; sampled on accept.
- divisor  input  WIDTH  rt operand; sampled on accept.
- annul  input  1  flush or exception; abandons any operation in flight.
- stall  output  1  pipeline stall request.
- result_valid  output  1  result is valid this cycle.
- result  output  2*WIDTH  [2W-1:W] = remainder (HI), [W-1:0] = quotient (LO).
- div_zero  output  1  divide-by-zero flag (see Optional Feature).

Behaviour:
- Reset:
  - state = IDLE; counter = 0.
  - result = 0, result_valid = 0, div_zero = 0; stall = 0 unless start is high with reset deasserted.
- States: IDLE, ZERO, BUSY, DONE.
- IDLE:
  - Accept when start && !annul.
  - On accept, latch |dividend| and |divisor| (absolute values only when signed_op; raw otherwise), latch the sign flags, clear counter.
  - Next state: ZERO if divisor == 0, else BUSY.
- BUSY:
  - One restoring step per cycle: shift {partial remainder, quotient} left by 1, trial-subtract divisor, set quotient bit on no-borrow.
  - counter += 1; when counter reaches WIDTH, go to DONE.
- ZERO: one cycle, then DONE with quotient = 0, remainder = 0.
- DONE:
  - result_valid = 1 and result is stable.
  - Signed fix-up is applied on entry to DONE: quotient negated iff the operand signs differ; remainder takes the dividend's sign.
  - Stays in DONE while start stays high; goes to IDLE in the cycle start drops.
  - result and result_valid clear on leaving DONE.
- Latency, nonzero divisor: accept edge, 32 BUSY edges, DONE; result_valid first high 33 cycles after the accept cycle.
- Latency, zero divisor: result_valid high 2 cycles after accept.
- stall (combinational):
  - 1 in ZERO and BUSY.
  - 1 in IDLE when start && !annul.
  - 0 in DONE, and 0 whenever annul is high.
- annul:
  - In any state, next state is IDLE, counter is cleared, nothing is written.
  - annul has priority over start on the same cycle.
- Reset mid-operation: reset wins over annul and over the state machine; next state is IDLE.
- Arithmetic corner: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps; no trap).
- start dropping during BUSY without annul: treated as annul.

Optional Feature:
- Macro DIV_ZERO_TRAP_EN.
- When defined: div_zero = 1 together with result_valid for an operation accepted with divisor == 0, and held through DONE. The result is still 0.
- When undefined: div_zero is tied to 0. The ZERO path and its 2-cycle latency are unchanged.

Decomposition:
- Shared defines file:
  - state encodings DIV_IDLE / DIV_ZERO / DIV_BUSY / DIV_DONE (2 bits);
  - divide width constant;
  - DivResultReady / DivResultNotReady, DivStart / DivStop.
- One natural sub-module, div_step: combinational single restoring iteration.
  - Inputs: {partial remainder, quotient}, divisor.
  - Output: next {partial remainder, quotient}.
  - div_control instantiates it once and registers its output each BUSY cycle.

Test Plan:
- DIVU 100 / 7 -> stall high for 33 cycles; result_valid at cycle 33; LO = 0x0000000E, HI = 0x00000002; start drop returns the block to IDLE next cycle.
- DIVU 0xFFFF0000 / 0x05050000 -> LO = 0x00000033, HI = 0x00000000; DIV with the same operands -> LO = 0x00000000, HI = 0xFFFF0000.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Divide by 0 -> result_valid 2 cycles after accept; result = 0; div_zero = 1 with DIV_ZERO_TRAP_EN, 0 without.
- annul at BUSY step 10 -> stall low the same cycle; IDLE next edge; no result_valid. A following DIVU 100 / 7 still completes correctly.
- reset low for 1 cycle during BUSY -> IDLE; result_valid = 0 and result = 0 after the edge. start and annul both high in IDLE -> no accept, stall = 0.
